// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// register-specifier width default and the hard-wired zero register.
package hazard_pkg;

  localparam int REG_W_DEF = 5;

  // Register 0 is hard-wired to zero, so writes to it never create a hazard.
  localparam int ZERO_REG = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_lu_detect.sv
// Load-use detector: flags an ID instruction that reads the destination of a
// load currently in EX. Purely combinational.
module lu_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] rs_ID,
  input  logic [REG_W-1:0] rt_ID,
  input  logic             use_rs_ID,
  input  logic             use_rt_ID,
  input  logic             memread_EX,
  input  logic [REG_W-1:0] rt_EX,
  output logic             lu
);

  logic dst_nonzero;
  logic rs_hit;
  logic rt_hit;

  always_comb begin
    dst_nonzero = (rt_EX != REG_W'(ZERO_REG));
    rs_hit      = use_rs_ID && (rs_ID == rt_EX);
    rt_hit      = use_rt_ID && (rt_ID == rt_EX);
    lu          = memread_EX && dst_nonzero && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, ID-resolved branch flushes
// and a freeze FSM for multi-cycle memory accesses. Optional HAZARD_PERF_EN adds perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs_ID,
  input  logic [REG_W-1:0] rt_ID,
  input  logic             use_rs_ID,
  input  logic             use_rt_ID,
  input  logic             memread_EX,
  input  logic [REG_W-1:0] rt_EX,
  input  logic             branch_taken_ID,
  input  logic             mem_req_MEM,
  input  logic             mem_ready_MEM,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             stall_back,
`ifdef HAZARD_PERF_EN
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt,
`endif
  output logic             mem_err,
  output logic [1:0]       state_o
);

  hz_state_t        state;
  logic [TMO_W-1:0] wait_cnt;
  logic             lu;
  logic             mw;

  lu_detect #(.REG_W(REG_W)) u_lu_detect (
    .rs_ID      (rs_ID),
    .rt_ID      (rt_ID),
    .use_rs_ID  (use_rs_ID),
    .use_rt_ID  (use_rt_ID),
    .memread_EX (memread_EX),
    .rt_EX      (rt_EX),
    .lu         (lu)
  );

  assign mw      = mem_req_MEM && !mem_ready_MEM;
  assign state_o = state;

  // wait_cnt counts MEM_WAIT cycles starting at 1; it stops at MEM_TIMEOUT
  // because the FSM leaves MEM_WAIT at that point, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mw) begin
            state    <= MEM_WAIT;
            wait_cnt <= TMO_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready_MEM) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == TMO_W'(MEM_TIMEOUT)) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TMO_W'(1);
          end
        end
        ERR: begin
          mem_err <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs decode the current state and inputs so they act on the next edge.
  // A branch that coincides with a load-use is dropped; it re-resolves after the bubble.
  always_comb begin
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    stall_back  = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (mw) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            stall_back  = 1'b1;
          end else if (lu) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (branch_taken_ID) begin
            flush_if_id = 1'b1;
          end
        end
        MEM_WAIT, ERR: begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          stall_back  = 1'b1;
        end
        default: begin
          stall_pc = 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_pc) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (flush_if_id || flush_id_ex) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. Drives the hold and clear controls of the PC, the IF/ID register, the ID/EX register and the back-end registers (ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards and taken branches/jumps resolved in ID.
- Runs a small FSM that freezes the pipeline while a multi-cycle data-memory access is outstanding.

Parameters:
REG_W, 5, register-specifier width
MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before mem_err asserts (≥2)
TMO_W, 5, timeout counter width; must hold MEM_TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rs_ID  in  REG_W  source reg 1 of instruction in ID
rt_ID  in  REG_W  source reg 2 of instruction in ID
use_rs_ID  in  1  ID instruction reads rs
use_rt_ID  in  1  ID instruction reads rt
memread_EX  in  1  instruction in EX is a load
rt_EX  in  REG_W  load destination in EX
branch_taken_ID  in  1  taken branch or jump resolved in ID
mem_req_MEM  in  1  MEM stage issues a data-memory access
mem_ready_MEM  in  1  data memory completes the access this cycle
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID (drives the IF/ID stall input)
flush_if_id  out  1  load IF/ID with NOP/zero
flush_id_ex  out  1  load ID/EX with bubble
stall_back  out  1  hold ID/EX, EX/MEM, MEM/WB
mem_err  out  1  sticky memory-timeout error
state_o  out  2  current FSM state, for debug

Behaviour:
- All outputs are combinational from the registered state and current inputs, so they take effect at the next clk edge. No extra latency.
- FSM states:
  - RUN=0
  - MEM_WAIT=1
  - ERR=2
- Reset (rst high at posedge): state=RUN, timeout counter=0, mem_err=0. While rst is high, all stall/flush outputs are 0. Reset mid-MEM_WAIT returns to RUN in one edge.
- Load-use hazard: lu = memread_EX && rt_EX!=0 && ((use_rs_ID && rs_ID==rt_EX) || (use_rt_ID && rt_ID==rt_EX)).
- Memory miss: mw = mem_req_MEM && !mem_ready_MEM.
- RUN:
  - If mw: stall_pc=stall_if_id=stall_back=1, flush=0; next state MEM_WAIT, counter=1.
  - Else if lu: stall_pc=stall_if_id=flush_id_ex=1. This inserts exactly one bubble, because the bubble clears memread_EX on the next cycle.
  - Else if branch_taken_ID: flush_if_id=1.
  - Else: all outputs 0.
  - Priority is mw > lu > branch. A branch coincident with lu is dropped and re-evaluated the next cycle, since its operands may depend on the load.
- MEM_WAIT:
  - stall_pc=stall_if_id=stall_back=1. lu and branch are ignored.
  - mem_ready_MEM=1 → outputs still stalled this cycle; next state RUN, counter=0.
  - Otherwise counter increments. When counter==MEM_TIMEOUT and ready is still low → next state ERR, mem_err=1.
- ERR: all stalls held (1); remains until rst; mem_err=1.
- Counter saturates and never wraps.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs perf_stall_cnt[31:0] (cycles with stall_pc=1) and perf_flush_cnt[31:0] (cycles with flush_if_id or flush_id_ex). Both reset to 0, increment by 1, and wrap at 2^32.
- Undefined: ports absent, no counters.

Decomposition:
- Shared package hazard_pkg:
  - state encoding (RUN/MEM_WAIT/ERR)
  - REG_W default
  - ZERO_REG constant
- One natural sub-module: lu_detect, purely combinational comparison of rs/rt against rt_EX. The FSM and counters stay in the top module.

Test Plan:
- Load-use: memread_EX=1, rt_EX=8, rs_ID=8, use_rs_ID=1 for one cycle → stall_pc=stall_if_id=flush_id_ex=1 exactly that cycle. Next cycle (memread_EX=0) → all 0.
- $0 guard: memread_EX=1, rt_EX=0, rs_ID=0, use_rs_ID=1 → no stall. Same case with use_rs_ID=0, rs_ID=rt_EX=5 → no stall.
- Branch: branch_taken_ID=1, no hazard → flush_if_id=1 for one cycle. Branch together with lu → only the lu outputs, flush_if_id=0.
- Memory wait:
  - mem_req_MEM=1, ready low for 3 cycles, then high → stall_back=1 for 4 cycles, state_o=1 for cycles 2-4, then RUN with all outputs 0.
- Timeout: ready never rises → ERR after MEM_TIMEOUT=16 wait cycles, mem_err=1 and sticky. Asserting rst → mem_err=0, state RUN.
- Reset mid-wait: rst during MEM_WAIT → next cycle state_o=0 and all outputs 0. With HAZARD_PERF_EN defined, counters read 0.
